// File: rtl/rsa_seq.sv
// rsa_seq: control sequencer between the SPI register file and the RSA
// modular-exponentiation core. Accepts a start strobe, snapshots the operands,
// forces a one-cycle core restart, supervises the run with a saturating cycle
// counter and timeout, and reports result, write strobe and status.
module rsa_seq #(
  parameter int WIDTH     = 5,
  parameter int REG_WIDTH = 8,
  parameter int CNT_W     = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [WIDTH-1:0]     p_i,
  input  logic [WIDTH-1:0]     e_i,
  input  logic [WIDTH-1:0]     m_i,
  input  logic [WIDTH-1:0]     const_i,
  output logic                 core_en_o,
  output logic [WIDTH-1:0]     core_p_o,
  output logic [WIDTH-1:0]     core_e_o,
  output logic [WIDTH-1:0]     core_m_o,
  output logic [WIDTH-1:0]     core_const_o,
  input  logic                 core_eoc_i,
  input  logic [WIDTH-1:0]     core_c_i,
  output logic [REG_WIDTH-1:0] result_o,
  output logic                 result_vld_o,
  output logic [REG_WIDTH-1:0] status_o,
  output logic [CNT_W-1:0]     cycles_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};
  // Value of the counter during the last RUN cycle before a timeout.
  localparam logic [CNT_W-1:0] CNT_TMO  = CNT_ONES - CNT_ONE;
  localparam logic [WIDTH-1:0] P_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           state_r;
  logic                 core_en_r;
  logic [WIDTH-1:0]     core_p_r;
  logic [WIDTH-1:0]     core_e_r;
  logic [WIDTH-1:0]     core_m_r;
  logic [WIDTH-1:0]     core_const_r;
  logic [REG_WIDTH-1:0] result_r;
  logic                 result_vld_r;
  logic                 done_r;
  logic                 busy_r;
  logic                 tmo_err_r;
  logic                 op_err_r;
  logic [CNT_W-1:0]     cycles_r;
  logic [CNT_W-1:0]     cnt_r;

  logic                 op_ok_s;
  logic                 accept_s;
  logic [CNT_W-1:0]     cnt_inc_s;
  logic [CNT_W-1:0]     cnt_next_s;

  // Decode operand validity, start acceptance and the saturating counter step.
  always_comb begin
    op_ok_s    = (p_i > P_ONE);
    accept_s   = (state_r == ST_IDLE) && start_i && op_ok_s;
    cnt_next_s = cnt_r + CNT_ONE;
    if (cnt_r == CNT_ONES) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_next_s;
    end
  end

  // Operand snapshot: loaded only on an accepted start, held for the whole run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_p_r     <= {WIDTH{1'b0}};
      core_e_r     <= {WIDTH{1'b0}};
      core_m_r     <= {WIDTH{1'b0}};
      core_const_r <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      core_p_r     <= p_i;
      core_e_r     <= e_i;
      core_m_r     <= m_i;
      core_const_r <= const_i;
    end
  end

  // Sequencer FSM: IDLE -> ARM (core held in restart) -> RUN -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      core_en_r    <= 1'b0;
      result_r     <= {REG_WIDTH{1'b0}};
      result_vld_r <= 1'b0;
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
      tmo_err_r    <= 1'b0;
      op_err_r     <= 1'b0;
      cycles_r     <= {CNT_W{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
    end else begin
      result_vld_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            // Any start in IDLE clears the sticky completion flags.
            done_r    <= 1'b0;
            tmo_err_r <= 1'b0;
            if (op_ok_s) begin
              op_err_r <= 1'b0;
              busy_r   <= 1'b1;
              state_r  <= ST_ARM;
            end else begin
              op_err_r <= 1'b1;
            end
          end
        end
        ST_ARM: begin
          cnt_r     <= {CNT_W{1'b0}};
          core_en_r <= 1'b1;
          state_r   <= ST_RUN;
        end
        ST_RUN: begin
          cnt_r <= cnt_inc_s;
          if (abort_i) begin
            // Abort beats eoc: any result arriving this cycle is dropped.
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
            core_en_r <= 1'b0;
            cycles_r  <= cnt_inc_s;
            state_r   <= ST_IDLE;
          end else if (core_eoc_i) begin
            result_r     <= {{(REG_WIDTH-WIDTH){1'b0}}, core_c_i};
            result_vld_r <= 1'b1;
            done_r       <= 1'b1;
            busy_r       <= 1'b0;
            core_en_r    <= 1'b0;
            cycles_r     <= cnt_inc_s;
            state_r      <= ST_IDLE;
          end else if (cnt_r == CNT_TMO) begin
            tmo_err_r <= 1'b1;
            busy_r    <= 1'b0;
            core_en_r <= 1'b0;
            cycles_r  <= CNT_ONES;
            state_r   <= ST_IDLE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          busy_r    <= 1'b0;
          core_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign core_en_o    = core_en_r;
  assign core_p_o     = core_p_r;
  assign core_e_o     = core_e_r;
  assign core_m_o     = core_m_r;
  assign core_const_o = core_const_r;
  assign result_o     = result_r;
  assign result_vld_o = result_vld_r;
  assign cycles_o     = cycles_r;
  assign status_o     = {{(REG_WIDTH-4){1'b0}}, op_err_r, tmo_err_r, busy_r, done_r};

endmodule

// File: doc/rsa_seq.md
# rsa_seq

Control sequencer between the SPI register file and the 5-bit RSA modular-exponentiation core. On a start strobe it snapshots the operand registers (P, E, M, Const) and restarts the core. It then supervises the computation with a cycle counter and timeout. At completion it returns a zero-extended result, a write strobe for register 6 and a status byte for register 0.

## Interface
Parameters:
- WIDTH, 5, operand/result width of the RSA core
- REG_WIDTH, 8, register-file data width
- CNT_W, 12, width of run-cycle counter; timeout at 2^CNT_W-1 cycles

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  single-cycle start strobe (Actions bit0 write)
- abort_i  in  1  single-cycle abort strobe
- p_i, e_i, m_i, const_i  in  WIDTH each  operand register values
- core_en_o  out  1  RSA core enable; core restarts while low
- core_p_o, core_e_o, core_m_o, core_const_o  out  WIDTH each  snapshotted operands to core
- core_eoc_i  in  1  core end-of-computation
- core_c_i  in  WIDTH  core result
- result_o  out  REG_WIDTH  last result, {zeros, C}
- result_vld_o  out  1  one-cycle write strobe for register 6
- status_o  out  REG_WIDTH  bit0 done, bit1 busy, bit2 timeout error, bit3 operand error, bits7:4 = 0
- cycles_o  out  CNT_W  RUN-cycle count of last finished/aborted/timed-out operation

## Operation
- Reset: state IDLE. All outputs 0, including core_en_o, snapshots, result_o, status_o, cycles_o and counter.
- IDLE (busy=0, core_en_o=0):
  - start_i with p_i < 2: set operand error bit, clear done and timeout. Core untouched; stay IDLE.
  - Otherwise, start_i: latch p/e/m/const into core_*_o, clear done/timeout/operand-error, set busy, go to ARM.
- ARM (busy=1, core_en_o=0): exactly one cycle, which guarantees a core restart. Clear the counter; go to RUN.
- RUN (busy=1, core_en_o=1): the counter increments every cycle, saturating at all-ones. Priority order per cycle:
  - abort_i: go to IDLE, busy=0, done=0, result_o unchanged, cycles_o <= counter+1.
  - core_eoc_i: result_o <= {0, core_c_i}, result_vld_o=1 next cycle, done=1, busy=0, cycles_o <= counter+1, go to IDLE.
  - Counter == 2^CNT_W-2 (this is the (2^CNT_W-1)th RUN cycle) with no eoc: timeout bit=1, busy=0, cycles_o <= all-ones, go to IDLE.
- eoc and timeout in the same cycle: eoc wins. abort and eoc in the same cycle: abort wins, result discarded.
- start_i in ARM/RUN is ignored, with no status change. abort_i in IDLE is ignored. core_eoc_i outside RUN is ignored.
- Status bits 0/2/3 are sticky until the next start_i accepted in IDLE.
- Snapshots hold while busy; operand register writes during RUN do not affect the core.
- Reset mid-operation: immediate return to the reset values above. No result_vld_o.

## Timing
- start_i sampled at edge t: busy=1 and snapshots valid after t; ARM is cycle t+1; core_en_o high after edge t+1 (first RUN cycle).
- eoc sampled at edge k: after k, result_o/status_o updated, result_vld_o high for exactly one cycle, core_en_o low.
- Back-to-back: a new start_i is accepted in the cycle result_vld_o is high (state already IDLE).
- Minimum operation is 3 cycles from start to result_vld_o (eoc on the first RUN cycle).
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- Reset mid-RUN: assert rst_n=0 asynchronously between edges -> core_en_o, status_o, result_o, cycles_o drop to 0 before the next edge. No result_vld_o after release.
- Normal run: P=29, E=5, M=7, Const=0x0A, start_i. Bench core model raises eoc with C=0x13 on the 20th cycle of core_en_o=1 -> result_o=0x13, result_vld_o one pulse, status_o=0x01, cycles_o=20, core_en_o low. Snapshot ports equal 29/5/7/0x0A throughout.
- Operand error: P=1, start_i -> status_o=0x08, core_en_o never rises, no result_vld_o. Then P=29, start_i -> bit3 clears, status_o=0x02 while busy.
- Timeout: CNT_W=4, core never asserts eoc -> after 15 RUN cycles status_o=0x04, cycles_o=0xF, core_en_o=0, no result_vld_o.
- Abort/eoc collision: abort_i and eoc (C=0x07) in the same RUN cycle -> status_o=0x00, result_o keeps its previous value, no result_vld_o.
- Busy protection: start_i and operand changes to P=3 mid-RUN -> ignored; core_p_o stays 29 and the run completes normally with status_o=0x01.
